// File: rtl/shift_cmd_seq.sv
// Command sequencer for a downstream shift register: accepts a mode/data/count
// command, enables the register for count cycles, then pulses done.
module shift_cmd_seq #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_mode,
  input  logic [7:0]       cmd_data,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic             abort,
  output logic             sr_enable,
  output logic [2:0]       sr_shift_direction,
  output logic [7:0]       sr_data_in,
  output logic             busy,
  output logic             done,
  output logic             done_aborted
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_W:0] CNT_ONE  = {{CNT_W{1'b0}}, 1'b1};
  localparam logic [CNT_W:0] CNT_FULL = {1'b1, {CNT_W{1'b0}}};

  state_t         state_reg;
  logic [CNT_W:0] cnt_reg;
  logic           last_run_cycle;

  assign last_run_cycle = (cnt_reg == CNT_ONE);

  // Every output is a register updated alongside the state, so no input
  // reaches an output without passing through a flop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg          <= IDLE;
      cnt_reg            <= '0;
      cmd_ready          <= 1'b1;
      sr_enable          <= 1'b0;
      sr_shift_direction <= 3'b000;
      sr_data_in         <= 8'h00;
      busy               <= 1'b0;
      done               <= 1'b0;
      done_aborted       <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            state_reg          <= RUN;
            sr_shift_direction <= cmd_mode;
            sr_data_in         <= cmd_data;
            // A zero count stands for the full 2^CNT_W range.
            cnt_reg            <= (cmd_count == '0) ? CNT_FULL : {1'b0, cmd_count};
            cmd_ready          <= 1'b0;
            sr_enable          <= 1'b1;
            busy               <= 1'b1;
          end
        end

        RUN: begin
          cnt_reg <= cnt_reg - CNT_ONE;
          if (last_run_cycle || abort) begin
            state_reg    <= DONE;
            sr_enable    <= 1'b0;
            done         <= 1'b1;
            // Normal completion wins over an abort on the final count edge.
            done_aborted <= !last_run_cycle;
          end
        end

        DONE: begin
          state_reg    <= IDLE;
          done         <= 1'b0;
          done_aborted <= 1'b0;
          busy         <= 1'b0;
          cmd_ready    <= 1'b1;
        end

        default: begin
          state_reg    <= IDLE;
          cnt_reg      <= '0;
          cmd_ready    <= 1'b1;
          sr_enable    <= 1'b0;
          busy         <= 1'b0;
          done         <= 1'b0;
          done_aborted <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_cmd_seq.sv
// Self-checking bench for shift_cmd_seq: directed scenarios plus randomized
// commands checked against a per-command timeline computed from count/abort.
module tb_shift_cmd_seq;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [2:0]       cmd_mode = '0;
  logic [7:0]       cmd_data = '0;
  logic [CNT_W-1:0] cmd_count = '0;
  logic             abort = 1'b0;
  logic             sr_enable;
  logic [2:0]       sr_shift_direction;
  logic [7:0]       sr_data_in;
  logic             busy;
  logic             done;
  logic             done_aborted;

  int n_checks = 0;
  int n_pass   = 0;

  logic [2:0] exp_mode = 3'b000;
  logic [7:0] exp_data = 8'h00;

  shift_cmd_seq #(.CNT_W(CNT_W)) dut (
    .clk                (clk),
    .reset              (reset),
    .cmd_valid          (cmd_valid),
    .cmd_ready          (cmd_ready),
    .cmd_mode           (cmd_mode),
    .cmd_data           (cmd_data),
    .cmd_count          (cmd_count),
    .abort              (abort),
    .sr_enable          (sr_enable),
    .sr_shift_direction (sr_shift_direction),
    .sr_data_in         (sr_data_in),
    .busy               (busy),
    .done               (done),
    .done_aborted       (done_aborted)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // One command: abort_at = k > 0 pulses abort in the k-th RUN cycle.
  // With N the effective count, the command runs E = (k in 1..N-1) ? k : N
  // enable cycles, then one done cycle, then one idle cycle.
  task automatic run_cmd(input logic [2:0] m, input logic [7:0] d,
                         input logic [CNT_W-1:0] c, input int abort_at, input bit noise);
    int  n;
    int  e;
    bit  ab;
    n  = (c == '0) ? (1 << CNT_W) : int'(c);
    ab = (abort_at > 0) && (abort_at < n);
    e  = ab ? abort_at : n;

    @(negedge clk);
    abort = 1'b0;
    chk("ready_before_cmd", cmd_ready, 1);
    chk("hold_dir", sr_shift_direction, exp_mode);
    chk("hold_data", sr_data_in, exp_data);
    cmd_valid = 1'b1;
    cmd_mode  = m;
    cmd_data  = d;
    cmd_count = c;
    exp_mode  = m;
    exp_data  = d;

    for (int i = 1; i <= e + 2; i++) begin
      @(negedge clk);
      chk("sr_enable", sr_enable, i <= e);
      chk("busy", busy, i <= e + 1);
      chk("done", done, i == e + 1);
      chk("done_aborted", done_aborted, (i == e + 1) && ab);
      chk("cmd_ready", cmd_ready, i == e + 2);
      chk("sr_dir", sr_shift_direction, m);
      chk("sr_data", sr_data_in, d);
      abort = (i == abort_at) || (noise && i > e && ($urandom_range(1) == 1));
      if (noise && i <= e + 1) begin
        cmd_valid = ($urandom_range(1) == 1);
        cmd_mode  = 3'($urandom);
        cmd_data  = 8'($urandom);
        cmd_count = CNT_W'($urandom);
      end else begin
        cmd_valid = 1'b0;
      end
    end
    $display("cmd mode=%b data=%h count=%0d abort_at=%0d -> enable_cycles=%0d aborted=%0d",
             m, d, c, abort_at, e, ab);
  endtask

  task automatic reset_mid_run();
    @(negedge clk);
    abort     = 1'b0;
    cmd_valid = 1'b1;
    cmd_mode  = 3'b101;
    cmd_data  = 8'h3C;
    cmd_count = CNT_W'(8);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("rst_run1_enable", sr_enable, 1);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("rst_async_enable", sr_enable, 0);
    chk("rst_async_busy", busy, 0);
    chk("rst_async_data", sr_data_in, 8'h00);
    chk("rst_async_dir", sr_shift_direction, 3'b000);
    chk("rst_async_ready", cmd_ready, 1);
    chk("rst_async_done", done, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("rst_hold_done", done, 0);
      chk("rst_hold_enable", sr_enable, 0);
    end
    reset     = 1'b1;
    cmd_valid = 1'b1;
    cmd_mode  = 3'b010;
    cmd_data  = 8'h81;
    cmd_count = CNT_W'(1);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("post_rst_accept", sr_enable, 1);
    chk("post_rst_data", sr_data_in, 8'h81);
    @(negedge clk);
    chk("post_rst_done", done, 1);
    @(negedge clk);
    chk("post_rst_ready", cmd_ready, 1);
    exp_mode = 3'b010;
    exp_data = 8'h81;
    $display("reset mid-run of count=8, then accept mode=010 data=81 count=1");
  endtask

  task automatic back_to_back();
    int first;
    int second;
    first  = -1;
    second = -1;
    @(negedge clk);
    abort     = 1'b0;
    cmd_valid = 1'b1;
    cmd_mode  = 3'b110;
    cmd_data  = 8'h5A;
    cmd_count = CNT_W'(2);
    for (int k = 0; k < 20 && second < 0; k++) begin
      if (k > 0) @(negedge clk);
      if (cmd_ready) begin
        if (first < 0) first = k;
        else second = k;
      end
    end
    cmd_valid = 1'b0;
    if (second < 0) chk("b2b_timeout", 0, 1);
    else chk("b2b_spacing", 32'(second - first), 4);
    for (int k = 0; k < 6; k++) @(negedge clk);
    chk("b2b_idle_ready", cmd_ready, 1);
    exp_mode = 3'b110;
    exp_data = 8'h5A;
    $display("back-to-back count=2 accepts at cycles %0d and %0d", first, second);
  endtask

  initial begin
    for (int k = 0; k < 3; k++) @(negedge clk);
    chk("reset_ready", cmd_ready, 1);
    chk("reset_enable", sr_enable, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_done_aborted", done_aborted, 0);
    chk("reset_dir", sr_shift_direction, 3'b000);
    chk("reset_data", sr_data_in, 8'h00);
    reset = 1'b1;

    run_cmd(3'b001, 8'hA5, CNT_W'(3), 0, 1'b0);
    run_cmd(3'b011, 8'h0F, CNT_W'(0), 0, 1'b0);
    run_cmd(3'b100, 8'hC3, CNT_W'(10), 4, 1'b0);
    run_cmd(3'b111, 8'h96, CNT_W'(5), 5, 1'b0);
    reset_mid_run();
    back_to_back();

    for (int t = 0; t < 40; t++) begin
      int ab_at;
      ab_at = ($urandom_range(1) == 1) ? int'($urandom_range(1, 18)) : 0;
      run_cmd(3'($urandom), 8'($urandom), CNT_W'($urandom), ab_at, 1'b1);
      for (int k = 0; k < int'($urandom_range(0, 3)); k++) @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/shift_cmd_seq.md
SHIFT_CMD_SEQ -- requirements
Module: shift_cmd_seq

Interface
REQ-001 The block SHALL have parameter CNT_W, default 4, giving the width of the shift-count field.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset (0 = reset asserted).
REQ-004 The block SHALL have port cmd_valid, input, 1 bit: a command is presented.
REQ-005 The block SHALL have port cmd_ready, output, 1 bit: the block accepts a command this cycle.
REQ-006 The block SHALL have port cmd_mode, input, 3 bits: shift mode for the downstream shift register.
REQ-007 The block SHALL have port cmd_data, input, 8 bits: parallel/fill data for the downstream shift register.
REQ-008 The block SHALL have port cmd_count, input, CNT_W bits: number of enabled shift cycles; 0 means 2^CNT_W.
REQ-009 The block SHALL have port abort, input, 1 bit: synchronous request to terminate the running command.
REQ-010 The block SHALL have port sr_enable, output, 1 bit: drives the shift register's enable.
REQ-011 The block SHALL have port sr_shift_direction, output, 3 bits: drives the shift register's shift_direction.
REQ-012 The block SHALL have port sr_data_in, output, 8 bits: drives the shift register's data_in.
REQ-013 The block SHALL have port busy, output, 1 bit: a command is in progress (RUN or DONE).
REQ-014 The block SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-015 The block SHALL have port done_aborted, output, 1 bit: qualifies done; 1 = the command ended by abort.

Function
REQ-016 The FSM SHALL have three states: IDLE, RUN and DONE; all outputs SHALL be decoded from registered state only, with no combinational path from input to output.
REQ-017 In IDLE: cmd_ready=1, sr_enable=0, busy=0, done=0.
REQ-018 Acceptance SHALL occur when cmd_valid=1 and cmd_ready=1 at a rising edge; at that edge the block captures cmd_mode into sr_shift_direction and cmd_data into sr_data_in, loads the counter with cmd_count (0 loaded as 2^CNT_W, counter width CNT_W+1) and moves to RUN.
REQ-019 In RUN: sr_enable=1, cmd_ready=0, busy=1; the counter decrements by 1 at each edge.
REQ-020 RUN SHALL last exactly N cycles, N being the effective count; after the edge where the counter reaches 0 the FSM enters DONE.
REQ-021 First sr_enable=1 cycle SHALL be the cycle immediately after acceptance (latency 1).
REQ-022 In DONE: done=1 for exactly one cycle, sr_enable=0, busy=1, cmd_ready=0; next state IDLE.
REQ-023 Command throughput SHALL be one command per N+2 cycles; cmd_valid in RUN/DONE is ignored and the command is held by the source.
REQ-024 sr_shift_direction and sr_data_in SHALL hold their captured values until the next acceptance, including through IDLE.
REQ-025 abort=1 sampled at an edge in RUN SHALL move the FSM to DONE with done_aborted=1; the RUN cycle in which abort was sampled still has sr_enable=1.
REQ-026 abort in IDLE or DONE SHALL be ignored; abort coincident with final count edge SHALL report done_aborted=0 (normal completion wins).
REQ-027 done_aborted SHALL be 0 whenever done=0.

Reset
REQ-028 reset=0 SHALL, asynchronously and regardless of state, force IDLE, counter=0, sr_enable=0, sr_shift_direction=3'b000, sr_data_in=8'h00, busy=0, done=0, done_aborted=0, cmd_ready=1.
REQ-029 Reset asserted mid-RUN SHALL drop sr_enable immediately, with no done pulse; the block SHALL accept a new command on the first edge after reset deassertion.

Verification
REQ-030 Accept mode=3'b001, data=8'hA5, count=3 -> sr_enable high for exactly 3 cycles starting 1 cycle after accept; sr_shift_direction=001, sr_data_in=A5; done pulse 1 cycle later; cmd_ready high again the following cycle.
REQ-031 count=0 with CNT_W=4 -> sr_enable high for exactly 16 cycles, then done=1, done_aborted=0.
REQ-032 count=10, abort pulsed in 4th RUN cycle -> 4 enable cycles, then done=1 with done_aborted=1.
REQ-033 abort asserted in the last (Nth) RUN cycle of count=5 -> 5 enable cycles, done_aborted=0.
REQ-034 reset driven low in 2nd RUN cycle of count=8 -> sr_enable, busy and sr_data_in are 0 immediately without waiting for clk, no done pulse; new command accepted on the first edge after release.
REQ-035 cmd_valid held high continuously with two back-to-back commands (count=2) -> second accepted on the edge leaving DONE/IDLE, giving a spacing of exactly 4 cycles between accepts.
